dm_write_logger: RTL and testbench
==================================

# dm_write_logger

Downstream observer of the RISC_V core's data-memory write port. Captures every store (address and write data) in a small FIFO and streams each one out over a valid/ready port as two 32-bit words: address first, then data. Sits beside data_memory on the same MEM_WRITE, ADDR and WRITE_DATA nets. Feeds a bench monitor or a debug UART bridge without stalling the core; on overflow it drops stores and records the loss.

## Interface
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- LO_ADDR, 32'h0000_0000, inclusive lower bound of the capture window; used only with DM_LOG_FILTER_EN.
- HI_ADDR, 32'hFFFF_FFFF, inclusive upper bound of the capture window; used only with DM_LOG_FILTER_EN.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- MEM_WRITE  in  1  store strobe from the core; one store per cycle while high.
- ADDR  in  32  store address.
- WRITE_DATA  in  32  store data.
- OUT_VALID  out  1  output word valid.
- OUT_READY  in  1  consumer accepts the word.
- OUT_DATA  out  32  address word or data word.
- OUT_LAST  out  1  high when OUT_DATA is the data word.
- COUNT  out  $clog2(DEPTH)+1  number of occupied entries.
- OVERFLOW  out  1  sticky; set when a store is dropped.
- DROP_CNT  out  16  count of dropped stores; saturates at 16'hFFFF.

## Operation
- Reset values: COUNT=0, OVERFLOW=0, DROP_CNT=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, state IDLE, both pointers 0.
- Push:
  - Occurs when MEM_WRITE=1 and the store is eligible. Without the macro every store is eligible.
  - Accepted if COUNT<DEPTH, or if a pop happens in the same cycle (pass-through when full).
  - A rejected push sets OVERFLOW and increments DROP_CNT, which saturates.
- Pop occurs on the handshake OUT_VALID & OUT_READY & OUT_LAST.
- Pointers wrap modulo DEPTH.
- COUNT next = COUNT + push − pop; a simultaneous push and pop leave COUNT unchanged.
- State machine:
  - IDLE: OUT_VALID=0, OUT_DATA=0. Moves to SEND_ADDR when COUNT>0 or a push is accepted.
  - SEND_ADDR: OUT_VALID=1, OUT_DATA=head address, OUT_LAST=0. Moves to SEND_DATA on OUT_READY.
  - SEND_DATA: OUT_VALID=1, OUT_DATA=head data, OUT_LAST=1. On OUT_READY it pops, then goes to SEND_ADDR if COUNT>1 or a push is accepted, otherwise to IDLE.
- Output ordering is strict FIFO. Address and data of one entry are never split by another entry.
- RST dominates every other input.
  - RST mid-transfer discards all entries and the partial transfer.
  - A MEM_WRITE in the reset cycle is ignored and does not count as a drop.

## Timing
- Capture latency: a store accepted at edge k is presented as OUT_VALID/address in the cycle after edge k, provided the FIFO was empty and the state was IDLE.
- Streaming throughput: one word per cycle with OUT_READY held high, i.e. one store per 2 cycles. A sustained store rate above 1 per 2 cycles eventually overflows.
- Hold rule: while OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_LAST hold stable.
- OUT_VALID never drops without a handshake, except on RST.
- COUNT, OVERFLOW and DROP_CNT are registered; they update at the edge that performs the push, pop or drop.
- OUT_READY may be high while OUT_VALID=0; this has no effect.

## Configuration
- Macro: DM_LOG_FILTER_EN.
- Defined: a store is eligible only if LO_ADDR ≤ ADDR ≤ HI_ADDR (unsigned compare). Out-of-window stores are ignored: no push, no drop, no OVERFLOW.
- Undefined: all stores are eligible, and LO_ADDR and HI_ADDR are unused.

## Test plan
- **Single store:** RST, then one store ADDR=0x100, WRITE_DATA=0xDEADBEEF, with OUT_READY=1 -> next cycle OUT_DATA=0x100 with OUT_LAST=0, following cycle 0xDEADBEEF with OUT_LAST=1; then IDLE with COUNT=0.
- **Overflow:** DEPTH=8, OUT_READY=0, 9 consecutive stores -> COUNT=8, OVERFLOW=1, DROP_CNT=1, and OUT_DATA holds the first address. Raising OUT_READY then drains 16 words, the first 8 stores in order.
- **Back-pressure:** OUT_READY toggles every cycle across 8 stores -> every word is stable while stalled and order is preserved; the total is 16 words.
- **Full pass-through:** FIFO full in SEND_DATA, store and OUT_READY=1 in the same cycle -> push accepted, COUNT stays 8, DROP_CNT unchanged.
- **Reset mid-transfer:** RST asserted during SEND_DATA with COUNT=3 and OVERFLOW=1 -> next cycle OUT_VALID=0, COUNT=0, OVERFLOW=0, DROP_CNT=0.
- **Filter (DM_LOG_FILTER_EN defined):** LO_ADDR=0x1000, HI_ADDR=0x1FFF; stores to 0x0FFC, 0x1000, 0x1FFC, 0x2000 -> only the 0x1000 and 0x1FFC pairs are emitted; DROP_CNT=0, OVERFLOW=0.

Source files
------------

// File: rtl/dm_write_logger.sv
// dm_write_logger: watches the data-memory store port and queues each store
// (address, data) in a small FIFO. Each entry is streamed out as two words,
// address first and then data, over a valid/ready port. When the FIFO is full,
// a store is dropped and the loss is recorded.
// Optional build macro: DM_LOG_FILTER_EN restricts capture to the window
// LO_ADDR..HI_ADDR (inclusive, unsigned).
// Handshake: a word moves when OUT_VALID & OUT_READY are both high at a rising
// CLK edge. Once OUT_VALID is high, it stays high with OUT_DATA/OUT_LAST stable
// until that handshake (RST excepted).
module dm_write_logger #(
    parameter int          DEPTH   = 8,
    parameter logic [31:0] LO_ADDR = 32'h0000_0000,
    parameter logic [31:0] HI_ADDR = 32'hFFFF_FFFF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     MEM_WRITE,
    input  logic [31:0]              ADDR,
    input  logic [31:0]              WRITE_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [31:0]              OUT_DATA,
    output logic                     OUT_LAST,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic [15:0]              DROP_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_ADDR = 2'd1,
        SEND_DATA = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          eligible, push, pop, drop;

`ifdef DM_LOG_FILTER_EN
    // Only stores inside the address window are of interest.
    assign eligible = MEM_WRITE && (ADDR >= LO_ADDR) && (ADDR <= HI_ADDR);
`else
    // Every store is logged; the window bounds have no effect in this build.
    logic unused_window;
    assign unused_window = ^{LO_ADDR, HI_ADDR};
    assign eligible      = MEM_WRITE;
`endif

    // Push/pop/drop decisions. A full FIFO still accepts a store when the head
    // leaves in the same cycle.
    always_comb begin
        pop  = (state == SEND_DATA) && OUT_READY;
        push = eligible && ((COUNT != FULL_CNT) || pop);
        drop = eligible && !push;
    end

    // Storage array. Only the pointers are reset; stale contents are never
    // presented because OUT_VALID depends on the state.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            addr_mem[wr_ptr] <= ADDR;
            data_mem[wr_ptr] <= WRITE_DATA;
        end
    end

    // Pointers, occupancy and loss bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            OVERFLOW <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   COUNT <= COUNT + CW'(1);
                2'b01:   COUNT <= COUNT - CW'(1);
                default: COUNT <= COUNT;
            endcase
            if (drop) begin
                OVERFLOW <= 1'b1;
                if (DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
            end
        end
    end

    // State register for the two-word output sequencer.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and output word selection.
    always_comb begin
        state_next = state;
        OUT_VALID  = 1'b0;
        OUT_DATA   = 32'd0;
        OUT_LAST   = 1'b0;
        case (state)
            IDLE: begin
                if ((COUNT != '0) || push) state_next = SEND_ADDR;
            end
            SEND_ADDR: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = addr_mem[rd_ptr];
                if (OUT_READY) state_next = SEND_DATA;
            end
            SEND_DATA: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = data_mem[rd_ptr];
                OUT_LAST  = 1'b1;
                if (OUT_READY) begin
                    if ((COUNT > CW'(1)) || push) state_next = SEND_ADDR;
                    else                           state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_write_logger.sv
// Testbench for dm_write_logger. The reference model is a queue of pending
// stores plus a flag for "address word already sent". Expected output words
// come from a scoreboard queue that is filled at push time.
`timescale 1ns/1ps
module tb_dm_write_logger;
  localparam int DEPTH = 8;
`ifdef DM_LOG_FILTER_EN
  localparam logic [31:0] LO = 32'h0000_1000;
  localparam logic [31:0] HI = 32'h0000_1FFF;
  localparam logic [31:0] SINGLE_ADDR = 32'h0000_1100;
`else
  localparam logic [31:0] LO = 32'h0000_0000;
  localparam logic [31:0] HI = 32'hFFFF_FFFF;
  localparam logic [31:0] SINGLE_ADDR = 32'h0000_0100;
`endif

  logic        CLK = 1'b0;
  logic        RST, MEM_WRITE, OUT_READY;
  logic [31:0] ADDR, WRITE_DATA;
  logic        OUT_VALID, OUT_LAST, OVERFLOW;
  logic [31:0] OUT_DATA;
  logic [$clog2(DEPTH):0] COUNT;
  logic [15:0] DROP_CNT;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [63:0] m_q[$];
  logic        m_phase;
  logic        m_ovf;
  logic [15:0] m_drop;
  // scoreboard: {last, word} in expected emission order
  logic [32:0] exp_q[$];

  dm_write_logger #(.DEPTH(DEPTH), .LO_ADDR(LO), .HI_ADDR(HI)) dut (
    .CLK(CLK), .RST(RST), .MEM_WRITE(MEM_WRITE), .ADDR(ADDR),
    .WRITE_DATA(WRITE_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .DROP_CNT(DROP_CNT)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  function automatic logic eligible(input logic [31:0] a);
`ifdef DM_LOG_FILTER_EN
    return (a >= LO) && (a <= HI);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] win_addr();
    return 32'h0000_1000 + ($urandom_range(0, 1023) << 2);
  endfunction

  // driver: apply one cycle of inputs, score any handshake, advance the model
  task automatic tick(input logic rst, input logic mw, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    logic pop_now;
    logic [32:0] w;
    RST = rst; MEM_WRITE = mw; ADDR = a; WRITE_DATA = d; OUT_READY = rdy;
    #1;
    if (!rst && OUT_VALID && rdy) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_word got=%h last=%b exp=none", OUT_DATA, OUT_LAST);
      end else begin
        w = exp_q.pop_front();
        if ({OUT_LAST, OUT_DATA} !== w) begin
          tests_failed++;
          $display("FAIL sb_word got=%b_%h exp=%b_%h", OUT_LAST, OUT_DATA, w[32], w[31:0]);
        end
      end
    end
    tests_run++;
    if (!rst && OUT_VALID !== (m_q.size() > 0)) begin
      tests_failed++;
      $display("FAIL out_valid got=%b exp=%b", OUT_VALID, m_q.size() > 0);
    end
    if (rst) begin
      m_q.delete(); exp_q.delete();
      m_phase = 1'b0; m_ovf = 1'b0; m_drop = 16'd0;
    end else begin
      pop_now = 1'b0;
      if (m_q.size() > 0 && rdy) begin
        if (m_phase) begin pop_now = 1'b1; m_phase = 1'b0; end
        else m_phase = 1'b1;
      end
      if (mw && eligible(a)) begin
        if (m_q.size() < DEPTH || pop_now) begin
          m_q.push_back({a, d});
          exp_q.push_back({1'b0, a});
          exp_q.push_back({1'b1, d});
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
      if (pop_now) void'(m_q.pop_front());
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({OUT_VALID, OUT_LAST, OVERFLOW} !== 3'b000 || OUT_DATA !== 32'd0 ||
        COUNT !== '0 || DROP_CNT !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_values got v=%b l=%b ovf=%b data=%h cnt=%0d drop=%0d exp all zero",
               OUT_VALID, OUT_LAST, OVERFLOW, OUT_DATA, COUNT, DROP_CNT);
    end
  endtask

  task automatic test_single_store();
    do_reset();
    tick(1'b0, 1'b1, SINGLE_ADDR, 32'hDEAD_BEEF, 1'b1);
    tests_run++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== SINGLE_ADDR || OUT_LAST !== 1'b0 || COUNT !== 1) begin
      tests_failed++;
      $display("FAIL single_addr got v=%b d=%h l=%b c=%0d exp v=1 d=%h l=0 c=1",
               OUT_VALID, OUT_DATA, OUT_LAST, COUNT, SINGLE_ADDR);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tests_run++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'hDEAD_BEEF || OUT_LAST !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_data got v=%b d=%h l=%b exp v=1 d=deadbeef l=1",
               OUT_VALID, OUT_DATA, OUT_LAST);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tests_run++;
    if (OUT_VALID !== 1'b0 || OUT_DATA !== 32'd0 || COUNT !== 0) begin
      tests_failed++;
      $display("FAIL single_idle got v=%b d=%h c=%0d exp v=0 d=0 c=0", OUT_VALID, OUT_DATA, COUNT);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] first_addr;
    do_reset();
    first_addr = win_addr();
    tick(1'b0, 1'b1, first_addr, $urandom(), 1'b0);
    for (int i = 1; i < 9; i++) tick(1'b0, 1'b1, win_addr(), $urandom(), 1'b0);
    tests_run++;
    if (COUNT !== 8 || OVERFLOW !== 1'b1 || DROP_CNT !== 16'd1 ||
        OUT_DATA !== first_addr || OUT_LAST !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_state got c=%0d ovf=%b drop=%0d d=%h l=%b exp c=8 ovf=1 drop=1 d=%h l=0",
               COUNT, OVERFLOW, DROP_CNT, OUT_DATA, OUT_LAST, first_addr);
    end
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tests_run++;
    if (COUNT !== 0 || OUT_VALID !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL overflow_drain got c=%0d v=%b words_left=%0d exp 0 0 0",
               COUNT, OUT_VALID, exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    int words = 0;
    logic held_pending = 1'b0;
    logic [31:0] held_data = 32'd0;
    logic held_last = 1'b0;
    logic rdy;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      rdy = i[0];
      if (held_pending) begin
        tests_run++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== held_data || OUT_LAST !== held_last) begin
          tests_failed++;
          $display("FAIL hold_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   OUT_VALID, OUT_DATA, OUT_LAST, held_data, held_last);
        end
      end
      if (OUT_VALID === 1'b1 && rdy) words++;
      held_pending = (OUT_VALID === 1'b1) && !rdy;
      held_data = OUT_DATA;
      held_last = OUT_LAST;
      tick(1'b0, i < 8, win_addr(), $urandom(), rdy);
      if (i >= 8 && m_q.size() == 0) break;
    end
    tests_run++;
    if (words != 16 || COUNT !== 0 || DROP_CNT !== 16'd0) begin
      tests_failed++;
      $display("FAIL back_pressure_total got words=%0d c=%0d drop=%0d exp 16 0 0", words, COUNT, DROP_CNT);
    end
  endtask

  task automatic test_pass_through();
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, win_addr(), $urandom(), 1'b0);
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tests_run++;
    if (OUT_LAST !== 1'b1 || COUNT !== 8) begin
      tests_failed++;
      $display("FAIL pass_setup got l=%b c=%0d exp l=1 c=8", OUT_LAST, COUNT);
    end
    tick(1'b0, 1'b1, win_addr(), $urandom(), 1'b1);
    tests_run++;
    if (COUNT !== 8 || DROP_CNT !== 16'd0 || OVERFLOW !== 1'b0 || OUT_LAST !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass_through got c=%0d drop=%0d ovf=%b l=%b exp c=8 drop=0 ovf=0 l=0",
               COUNT, DROP_CNT, OVERFLOW, OUT_LAST);
    end
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tests_run++;
    if (COUNT !== 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pass_drain got c=%0d words_left=%0d exp 0 0", COUNT, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, win_addr(), $urandom(), 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tests_run++;
    if (OUT_LAST !== 1'b1 || COUNT !== 3 || OVERFLOW !== 1'b1 || DROP_CNT !== 16'd1) begin
      tests_failed++;
      $display("FAIL rst_mid_setup got l=%b c=%0d ovf=%b drop=%0d exp l=1 c=3 ovf=1 drop=1",
               OUT_LAST, COUNT, OVERFLOW, DROP_CNT);
    end
    tick(1'b1, 1'b1, win_addr(), $urandom(), 1'b1);
    tests_run++;
    if (OUT_VALID !== 1'b0 || COUNT !== 0 || OVERFLOW !== 1'b0 || DROP_CNT !== 16'd0 || OUT_DATA !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid got v=%b c=%0d ovf=%b drop=%0d d=%h exp all zero",
               OUT_VALID, COUNT, OVERFLOW, DROP_CNT, OUT_DATA);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tests_run++;
    if (OUT_VALID !== 1'b0 || COUNT !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_after got v=%b c=%0d exp v=0 c=0", OUT_VALID, COUNT);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 1) == 1) ? win_addr() : $urandom();
      tick(1'b0, $urandom_range(0, 99) < 65, a, $urandom(), $urandom_range(0, 99) < 70);
      tests_run++;
      if (COUNT !== m_q.size() || OVERFLOW !== m_ovf || DROP_CNT !== m_drop) begin
        tests_failed++;
        $display("FAIL random_state cyc=%0d got c=%0d ovf=%b drop=%0d exp c=%0d ovf=%b drop=%0d",
                 i, COUNT, OVERFLOW, DROP_CNT, m_q.size(), m_ovf, m_drop);
      end
    end
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    tests_run++;
    if (COUNT !== 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL random_drain got c=%0d words_left=%0d exp 0 0", COUNT, exp_q.size());
    end
  endtask

`ifdef DM_LOG_FILTER_EN
  task automatic test_filter();
    logic [31:0] got[$];
    logic [31:0] d[4];
    logic [31:0] addrs[4];
    addrs[0] = 32'h0FFC; addrs[1] = 32'h1000; addrs[2] = 32'h1FFC; addrs[3] = 32'h2000;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (OUT_VALID === 1'b1) got.push_back(OUT_DATA);
      if (i < 4) begin
        d[i] = $urandom();
        tick(1'b0, 1'b1, addrs[i], d[i], 1'b1);
      end else tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    tests_run++;
    if (got.size() != 4 || got[0] !== 32'h1000 || got[1] !== d[1] ||
        got[2] !== 32'h1FFC || got[3] !== d[2] || DROP_CNT !== 16'd0 || OVERFLOW !== 1'b0) begin
      tests_failed++;
      $display("FAIL filter got n=%0d drop=%0d ovf=%b exp n=4 words 1000,%h,1ffc,%h drop=0 ovf=0",
               got.size(), DROP_CNT, OVERFLOW, d[1], d[2]);
    end
  endtask
`endif

  initial begin
    RST = 1'b1; MEM_WRITE = 1'b0; ADDR = 32'd0; WRITE_DATA = 32'd0; OUT_READY = 1'b0;
    m_phase = 1'b0; m_ovf = 1'b0; m_drop = 16'd0;
    @(negedge CLK);
    test_reset();
    test_single_store();
    test_overflow();
    test_back_pressure();
    test_pass_through();
    test_reset_mid_transfer();
    test_random();
`ifdef DM_LOG_FILTER_EN
    test_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
